// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit buffer, the transmitter and the receiver.
package uart_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef logic [7:0] uart_byte_t;
endpackage

// File: rtl/uart_tx_buffer_if.sv
// Core-side write port and transmitter-side read port of the UART transmit buffer.
interface uart_tx_buffer_if;
    import uart_pkg::*;

    logic [31:0] in_data;
    logic        in_word;
    logic        in_valid;
    logic        in_ready;
    uart_byte_t  out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_data, in_word, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport master (
        output in_data, in_word, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO ahead of the UART transmitter; words are split into bytes MSB first.
// Optional dropped-write counter enabled by defining UART_TX_OVF_COUNT_EN.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    uart_tx_buffer_if.slave          bus,
    output logic [ADDR_WIDTH:0]      level,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WORD_L  = (ADDR_WIDTH + 1)'(BYTES_PER_WORD);

    uart_byte_t            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   push_n;
    logic                  push;
    logic                  pop;

    // Ready only looks at headroom, never at in_word, so it is data independent.
    assign bus.in_ready  = RSTN && ((DEPTH_L - count) >= WORD_L);
    assign bus.out_valid = RSTN && (count != '0);
    assign bus.out_data  = mem[rd_ptr];
    assign level         = count;

    assign push   = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;
    assign push_n = push ? (bus.in_word ? WORD_L : (ADDR_WIDTH + 1)'(1)) : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            if (bus.in_word) begin
                for (int i = 0; i < BYTES_PER_WORD; i++) begin
                    mem[wr_ptr + ADDR_WIDTH'(i)] <= bus.in_data[8*(BYTES_PER_WORD-1-i) +: 8];
                end
            end else begin
                mem[wr_ptr] <= bus.in_data[7:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_n[ADDR_WIDTH-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + push_n - {{ADDR_WIDTH{1'b0}}, pop};
        end
    end

`ifdef UART_TX_OVF_COUNT_EN
    logic [OVF_CNT_WIDTH-1:0] ovf_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ovf_q <= '0;
        end else if (bus.in_valid && !bus.in_ready && (ovf_q != '1)) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = '0;
`endif

endmodule
